pc_next_unit: RTL

//   Program-counter register stage fed by the PC-source select (2-bit code:
//   0 = sequential, 1 = branch/jump target, 2 = memory-indirect jump).

---
 rtl/pc_next_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Program-counter register stage. Holds the architectural PC and updates it
//   once per accepted PC-source select. Code 2 (memory-indirect jump) runs a
//   single read on the memory port and loads the returned word into the PC.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst        in   1    asynchronous reset, active-high
//   sel_valid  in   1    pc_sel/target valid this cycle
//   pc_sel     in   2    0 inc, 1 target, 2 mem-indirect, 3 illegal
//   target     in   AW   branch/jump operand address
//   stall      in   1    blocks acceptance of sel_valid
//   mem_req    out  1    indirect-jump read request
//   mem_addr   out  AW   read address (target captured at accept)
//   mem_gnt    in   1    memory accepted mem_req this cycle
//   mem_valid  in   1    mem_rdata valid this cycle
//   mem_rdata  in   AW   indirect jump destination
//   pc         out  AW   current program counter / fetch address
//   busy       out  1    indirect jump in flight
//   sel_err    out  1    sticky: illegal pc_sel was accepted
//   dbg_state  out  2    current FSM state (0 idle, 1 req, 2 wait)
//
// Handshakes: a select transfers on a cycle with sel_valid=1, stall=0 and
// busy=0; selects offered while busy=1 are dropped, not queued. The memory
// request transfers on the cycle mem_req=1 and mem_gnt=1; mem_req stays
// asserted with mem_addr stable until then. Read data transfers on the first
// mem_valid=1 cycle after the grant cycle; mem_valid at other times is ignored.
module pc_next_unit #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel_valid,
    input  logic [1:0]    pc_sel,
    input  logic [AW-1:0] target,
    input  logic          stall,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rdata,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          sel_err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_mem_addr;
    logic          r_sel_err;
    logic          w_accept;

    assign w_accept = sel_valid & ~stall & (r_state == S_IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (pc_sel == 2'd2)) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_valid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // PC, captured read address and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_mem_addr <= '0;
            r_sel_err  <= 1'b0;
        end else if (w_accept) begin
            case (pc_sel)
                2'd0:    r_pc       <= r_pc + {{(AW-1){1'b0}}, 1'b1};
                2'd1:    r_pc       <= target;
                2'd2:    r_mem_addr <= target;
                default: r_sel_err  <= 1'b1;
            endcase
        end else if ((r_state == S_WAIT) && mem_valid) begin
            r_pc <= mem_rdata;
        end
    end

    // Outputs are pure decodes of registered state
    assign mem_req   = (r_state == S_REQ);
    assign busy      = (r_state != S_IDLE);
    assign mem_addr  = r_mem_addr;
    assign pc        = r_pc;
    assign sel_err   = r_sel_err;
    assign dbg_state = r_state;

endmodule
